// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one load/store at a time, services it against a
// little-endian byte array after LATENCY cycles, and returns data over a valid/ready channel.
module data_mem_responder #(
   parameter int DEPTH_BYTES = 64,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [63:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int AW = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t      r_state;
   logic [3:0]  r_cnt;
   logic        r_write;
   logic [1:0]  r_size;
   logic        r_unsigned;
   logic [63:0] r_addr;
   logic [63:0] r_wdata;
   logic [63:0] r_rdata;
   logic        r_err;
   logic [7:0]  r_mem [DEPTH_BYTES];

   logic [3:0]       w_nbytes;
   logic [2:0]       w_align_mask;
   logic [64:0]      w_end;
   logic             w_err;
   logic [AW-1:0]    w_base;
   logic [7:0][7:0]  w_lane;
   logic [7:0]       w_lane_en;
   logic [63:0]      w_raw;
   logic [63:0]      w_load;

   assign w_nbytes = 4'd1 << r_size;

   always_comb begin
      w_align_mask = 3'd0;
      case (r_size)
         2'd0:    w_align_mask = 3'd0;
         2'd1:    w_align_mask = 3'd1;
         2'd2:    w_align_mask = 3'd3;
         default: w_align_mask = 3'd7;
      endcase
   end

   // End address is formed in 65 bits so addresses near 2^64 cannot wrap into range.
   assign w_end  = {1'b0, r_addr} + {61'd0, w_nbytes};
   assign w_err  = (|(r_addr[2:0] & w_align_mask)) || (w_end > 65'(DEPTH_BYTES));
   assign w_base = r_addr[AW-1:0];

   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_lane
         assign w_lane_en[gi] = (4'(gi) < w_nbytes);
         assign w_lane[gi]    = w_lane_en[gi] ? r_mem[w_base + AW'(gi)] : 8'h00;
      end
   endgenerate

   assign w_raw = w_lane;

   always_comb begin
      w_load = w_raw;
      case (r_size)
         2'd0:    w_load = {{56{~r_unsigned & w_raw[7]}},  w_raw[7:0]};
         2'd1:    w_load = {{48{~r_unsigned & w_raw[15]}}, w_raw[15:0]};
         2'd2:    w_load = {{32{~r_unsigned & w_raw[31]}}, w_raw[31:0]};
         default: w_load = w_raw;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= IDLE;
         r_cnt      <= 4'd0;
         r_write    <= 1'b0;
         r_size     <= 2'd0;
         r_unsigned <= 1'b0;
         r_addr     <= 64'd0;
         r_wdata    <= 64'd0;
         r_rdata    <= 64'd0;
         r_err      <= 1'b0;
         for (int i = 0; i < DEPTH_BYTES; i++) r_mem[i] <= 8'h00;
      end else begin
         case (r_state)
            IDLE: begin
               if (req_valid) begin
                  r_write    <= req_write;
                  r_size     <= req_size;
                  r_unsigned <= req_unsigned;
                  r_addr     <= req_addr;
                  r_wdata    <= req_wdata;
                  r_cnt      <= 4'(LATENCY - 1);
                  r_state    <= BUSY;
               end
            end
            BUSY: begin
               if (r_cnt == 4'd0) begin
                  r_err   <= w_err;
                  r_rdata <= (w_err || r_write) ? 64'd0 : w_load;
                  if (r_write && !w_err) begin
                     for (int i = 0; i < 8; i++)
                        if (w_lane_en[i]) r_mem[w_base + AW'(i)] <= r_wdata[8*i +: 8];
                  end
                  r_state <= RESP;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            RESP: begin
               if (rsp_ready) r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Ready is gated by reset so it reads 0 while reset is held.
   assign req_ready = reset_n && (r_state == IDLE);
   assign rsp_valid = (r_state == RESP);
   assign rsp_rdata = r_rdata;
   assign rsp_err   = r_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed cases, stall/hold, back-to-back,
// mid-operation reset and randomized traffic against a byte-array reference model.
module tb_data_mem_responder;

   localparam int DEPTH = 64;
   localparam int LAT   = 2;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [1:0]  req_size = 2'd0;
   logic        req_unsigned = 1'b0;
   logic [63:0] req_addr = 64'd0;
   logic [63:0] req_wdata = 64'd0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [63:0] rsp_rdata;
   logic        rsp_err;

   int n_checks = 0;
   int n_fail   = 0;
   logic [7:0] mdl [DEPTH];

   data_mem_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(LAT)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1);
   end

   // Reference model: a plain byte array with arithmetic sign extension.
   function automatic void model_access(input logic w, input logic [1:0] sz, input logic un,
                                        input logic [63:0] a, input logic [63:0] wd,
                                        output logic [63:0] rd, output logic er);
      int n;
      n  = 1 << sz;
      er = ((a % 64'(n)) != 64'd0) || (a > 64'(DEPTH - n));
      rd = 64'd0;
      if (er) return;
      if (w) begin
         for (int i = 0; i < n; i++) mdl[int'(a) + i] = 8'(wd >> (8 * i));
      end else begin
         for (int i = 0; i < n; i++) rd = rd | (64'(mdl[int'(a) + i]) << (8 * i));
         if (!un && n < 8 && rd[8 * n - 1]) rd = rd - (64'd1 << (8 * n));
      end
   endfunction

   task automatic issue(input logic w, input logic [1:0] sz, input logic un,
                        input logic [63:0] a, input logic [63:0] wd,
                        output logic [63:0] rd, output logic er, output int lat,
                        output logic idle_after);
      int k;
      @(negedge clk);
      req_write = w; req_size = sz; req_unsigned = un; req_addr = a; req_wdata = wd;
      req_valid = 1'b1; rsp_ready = 1'b1;
      k = 0;
      while (!req_ready && k < 100) begin @(negedge clk); k++; end
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};
      req_write = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
      lat = 0;
      do begin @(posedge clk); #1; lat++; end while (!rsp_valid && lat < 50);
      rd = rsp_rdata;
      er = rsp_err;
      @(posedge clk); #1;
      idle_after = req_ready && !rsp_valid;
      $display("txn w=%0d sz=%0d uns=%0d addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d",
               w, sz, un, a, wd, rd, er, lat);
   endtask

   task automatic test_reset();
      #1;
      n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 0", req_ready); end
      n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
      n_checks++; if (rsp_rdata !== 64'd0) begin n_fail++; $display("FAIL reset_rsp_rdata: got %h expected 0", rsp_rdata); end
      n_checks++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err: got %b expected 0", rsp_err); end
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      #1;
      n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b expected 1", req_ready); end
      for (int i = 0; i < DEPTH; i++) mdl[i] = 8'h00;
   endtask

   typedef struct packed {
      logic        w;
      logic [1:0]  sz;
      logic        un;
      logic [63:0] a;
      logic [63:0] wd;
      logic [63:0] exp_rd;
      logic        exp_er;
   } dir_t;

   task automatic test_directed();
      dir_t tbl [11];
      logic [63:0] rd, mrd;
      logic er, mer, idle;
      int lat;
      tbl = '{
         '{1'b1, 2'd3, 1'b0, 64'd8,  64'h8877665544332211, 64'd0, 1'b0},
         '{1'b0, 2'd3, 1'b0, 64'd8,  64'd0, 64'h8877665544332211, 1'b0},
         '{1'b0, 2'd0, 1'b0, 64'd15, 64'd0, 64'hFFFFFFFFFFFFFF88, 1'b0},
         '{1'b0, 2'd0, 1'b1, 64'd15, 64'd0, 64'h0000000000000088, 1'b0},
         '{1'b0, 2'd1, 1'b0, 64'd8,  64'd0, 64'h0000000000002211, 1'b0},
         '{1'b0, 2'd2, 1'b0, 64'd12, 64'd0, 64'hFFFFFFFF88776655, 1'b0},
         '{1'b1, 2'd0, 1'b0, 64'd9,  64'h00000000000000AB, 64'd0, 1'b0},
         '{1'b0, 2'd3, 1'b0, 64'd8,  64'd0, 64'h887766554433AB11, 1'b0},
         '{1'b0, 2'd2, 1'b0, 64'd6,  64'd0, 64'd0, 1'b1},
         '{1'b1, 2'd3, 1'b0, 64'd64, 64'hDEADBEEFCAFEF00D, 64'd0, 1'b1},
         '{1'b0, 2'd3, 1'b0, 64'd56, 64'd0, 64'd0, 1'b0}
      };
      for (int t = 0; t < 11; t++) begin
         issue(tbl[t].w, tbl[t].sz, tbl[t].un, tbl[t].a, tbl[t].wd, rd, er, lat, idle);
         model_access(tbl[t].w, tbl[t].sz, tbl[t].un, tbl[t].a, tbl[t].wd, mrd, mer);
         n_checks++; if (rd !== tbl[t].exp_rd) begin n_fail++; $display("FAIL directed_rdata[%0d]: got %h expected %h", t, rd, tbl[t].exp_rd); end
         n_checks++; if (er !== tbl[t].exp_er) begin n_fail++; $display("FAIL directed_err[%0d]: got %b expected %b", t, er, tbl[t].exp_er); end
         n_checks++; if (lat != LAT) begin n_fail++; $display("FAIL directed_latency[%0d]: got %0d expected %0d", t, lat, LAT); end
         n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL directed_idle_after[%0d]: got %b expected 1", t, idle); end
      end
   endtask

   task automatic test_hold();
      logic [63:0] exp_rd, rd;
      logic exp_er, er, idle;
      int k, lat;
      model_access(1'b0, 2'd3, 1'b0, 64'd8, 64'd0, exp_rd, exp_er);
      @(negedge clk);
      req_write = 1'b0; req_size = 2'd3; req_unsigned = 1'b0; req_addr = 64'd8;
      req_valid = 1'b1; rsp_ready = 1'b0;
      @(posedge clk); #1;
      req_valid = 1'b0;
      k = 0;
      while (!rsp_valid && k < 50) begin @(posedge clk); #1; k++; end
      n_checks++; if (rsp_rdata !== exp_rd) begin n_fail++; $display("FAIL hold_rdata: got %h expected %h", rsp_rdata, exp_rd); end
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         req_valid = 1'($urandom); req_addr = 64'($urandom_range(0, 63));
         req_write = 1'b1; req_size = 2'($urandom); req_wdata = {$urandom, $urandom};
         @(posedge clk); #1;
         n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid[%0d]: got %b expected 1", c, rsp_valid); end
         n_checks++; if (rsp_rdata !== exp_rd) begin n_fail++; $display("FAIL hold_stable_rdata[%0d]: got %h expected %h", c, rsp_rdata, exp_rd); end
         n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL hold_req_ready[%0d]: got %b expected 0", c, req_ready); end
      end
      @(negedge clk);
      req_valid = 1'b0; rsp_ready = 1'b1;
      @(posedge clk); #1;
      n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL hold_release_valid: got %b expected 0", rsp_valid); end
      n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL hold_release_ready: got %b expected 1", req_ready); end
      $display("txn hold load addr=8 -> rdata=%h", exp_rd);
      issue(1'b0, 2'd3, 1'b0, 64'd8, 64'd0, rd, er, lat, idle);
      n_checks++; if (rd !== exp_rd) begin n_fail++; $display("FAIL hold_no_accept: got %h expected %h", rd, exp_rd); end
   endtask

   task automatic test_back_to_back();
      int acc [3];
      int n_acc, cyc;
      @(negedge clk);
      req_write = 1'b0; req_size = 2'd3; req_unsigned = 1'b0; req_addr = 64'd0;
      req_valid = 1'b1; rsp_ready = 1'b1;
      n_acc = 0; cyc = 0;
      while (n_acc < 3 && cyc < 60) begin
         if (req_ready) begin acc[n_acc] = cyc; n_acc++; end
         @(negedge clk); cyc++;
      end
      req_valid = 1'b0;
      repeat (LAT + 3) @(negedge clk);
      n_checks++; if (n_acc != 3) begin n_fail++; $display("FAIL b2b_accepts: got %0d expected 3", n_acc); end
      for (int i = 1; i < 3; i++) begin
         n_checks++;
         if (n_acc == 3 && acc[i] - acc[i-1] != LAT + 2) begin
            n_fail++; $display("FAIL b2b_period[%0d]: got %0d expected %0d", i, acc[i] - acc[i-1], LAT + 2);
         end else if (n_acc != 3) n_fail++;
      end
      $display("txn back-to-back accepts=%0d", n_acc);
   endtask

   task automatic test_reset_mid();
      logic [63:0] rd;
      logic er, idle;
      int lat;
      @(negedge clk);
      req_write = 1'b1; req_size = 2'd3; req_addr = 64'd0; req_wdata = 64'd1;
      req_valid = 1'b1; rsp_ready = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #3;
      reset_n = 1'b0;
      #1;
      n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_req_ready: got %b expected 0", req_ready); end
      n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_rsp_valid: got %b expected 0", rsp_valid); end
      n_checks++; if (rsp_rdata !== 64'd0) begin n_fail++; $display("FAIL midrst_rdata: got %h expected 0", rsp_rdata); end
      for (int i = 0; i < DEPTH; i++) mdl[i] = 8'h00;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      $display("txn reset during busy store addr=0");
      issue(1'b0, 2'd3, 1'b0, 64'd0, 64'd0, rd, er, lat, idle);
      n_checks++; if (rd !== 64'd0) begin n_fail++; $display("FAIL midrst_load0: got %h expected 0", rd); end
      n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL midrst_err0: got %b expected 0", er); end
      issue(1'b0, 2'd3, 1'b0, 64'd8, 64'd0, rd, er, lat, idle);
      n_checks++; if (rd !== 64'd0) begin n_fail++; $display("FAIL midrst_cleared8: got %h expected 0", rd); end
   endtask

   task automatic test_random();
      logic [63:0] a, wd, rd, mrd;
      logic w, un, er, mer, idle;
      logic [1:0] sz;
      int r, lat;
      for (int t = 0; t < 60; t++) begin
         sz = 2'($urandom_range(0, 3));
         w  = 1'($urandom_range(0, 2) == 0);
         un = 1'($urandom);
         wd = {$urandom, $urandom};
         r  = $urandom_range(0, 15);
         if (r == 0)      a = 64'hFFFF_FFFF_FFFF_FFF8;
         else if (r < 3)  a = 64'($urandom_range(0, 80));
         else             a = 64'($urandom_range(0, 63) & ~((1 << sz) - 1));
         issue(w, sz, un, a, wd, rd, er, lat, idle);
         model_access(w, sz, un, a, wd, mrd, mer);
         n_checks++; if (rd !== mrd) begin n_fail++; $display("FAIL rand_rdata[%0d]: got %h expected %h", t, rd, mrd); end
         n_checks++; if (er !== mer) begin n_fail++; $display("FAIL rand_err[%0d]: got %b expected %b", t, er, mer); end
         n_checks++; if (lat != LAT) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", t, lat, LAT); end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_hold();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Responder end of the data-memory access interface: accepts load/store requests from a requesting master (the datapath's memory stage or a bench sequencer), services them against an internal little-endian byte array after a fixed latency, and returns read data or a write acknowledgement over a valid/ready response channel. It provides variable-latency memory behaviour for exercising the stall logic of the pipelined core.

## Interface
- DEPTH_BYTES, 64: size of the byte array; byte-addressed, addresses 0..DEPTH_BYTES-1
- LATENCY, 2: cycles from request acceptance to response valid; legal range 1..15

- clk  in  1  clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 doubleword
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend
- req_addr  in  64  byte address
- req_wdata  in  64  store data; the low 8·2^req_size bits are used
- rsp_valid  out  1  response present
- rsp_ready  in  1  master accepts response
- rsp_rdata  out  64  load result; 0 for stores and errors
- rsp_err  out  1  request was misaligned or out of range

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready, latch write/size/unsigned/addr/wdata, load counter with LATENCY-1, go to BUSY.
- BUSY: req_ready=0, rsp_valid=0. Counter decrements each cycle; at counter==0 the transition edge performs the access and moves to RESP.
- Access (on BUSY→RESP edge): err = (addr mod 2^size ≠ 0) or (addr + 2^size > DEPTH_BYTES), computed on the full 64-bit addr, with no wrap-around. If err: no array write, rdata=0, rsp_err=1. Store: write bytes addr..addr+2^size-1 from wdata low bytes, little-endian; rdata=0. Load: assemble bytes little-endian, then extend to 64 bits (sign from MSB of accessed field unless unsigned; doubleword ignores req_unsigned).
- RESP: rsp_valid=1, rsp_rdata/rsp_err held stable until rsp_valid&&rsp_ready; on that edge go to IDLE.
- Request fields are ignored outside the accept edge; changes during BUSY/RESP have no effect.
- Only one outstanding request; no request is accepted in the cycle a response is consumed.

## Timing
- Reset (async assert): state=IDLE, req_ready=1 after reset deasserts (0 while asserted), rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0, entire byte array cleared to 0.
- Reset asserted mid-operation: request discarded; a store not yet committed (still BUSY) must not modify the array (the array is cleared anyway).
- Accept at edge E: rsp_valid rises after edge E+LATENCY; a store is visible to any request accepted after that edge.
- Minimum request period: LATENCY+2 cycles with rsp_ready held 1 (accept, LATENCY in BUSY, handshake edge back to IDLE, next accept).
- rsp_ready low holds RESP indefinitely; outputs must not change.
- req_ready is combinational from state only (no dependence on req_valid).

## Test plan
- Reset then DW store addr=8 data=64'h8877665544332211, then DW load addr=8 -> rsp_rdata=64'h8877665544332211, rsp_err=0; rsp_valid rises exactly LATENCY cycles after each accept edge.
- After the above: byte load addr=15 signed -> 64'hFFFFFFFFFFFFFF88; unsigned -> 64'h0000000000000088; half load addr=8 -> 64'h0000000000002211; word load addr=12 signed -> 64'hFFFFFFFF88776655.
- Byte store addr=9 data=64'hAB, then DW load addr=8 -> 64'h887766554433AB11 (only one byte modified).
- Misaligned word load addr=6 -> rsp_err=1, rsp_rdata=0; DW store addr=64 (DEPTH 64) -> rsp_err=1, following DW load addr=56 returns 0 (no wrap write).
- Hold rsp_ready=0 for 5 cycles in RESP while toggling req_valid/req_addr -> rsp_valid and rsp_rdata stable, req_ready=0, no new accept; raise rsp_ready -> IDLE next cycle.
- Assert reset_n=0 while BUSY on a store to addr=0 data=1 -> outputs zero immediately; after release DW load addr=0 returns 0, rsp_err=0.
